// File: rtl/multi_digit_display_driver.sv
// Multiplexed hex display driver: scans DIGITS digits (one-hot anode select,
// seven-segment font, decimal point) at SCAN_DIV clocks per digit slot. New
// display contents are staged in a pending register through a valid/ready
// handshake and applied only at a frame boundary, so a frame never tears.
module multi_digit_display_driver #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                blank_lz,
    input  logic [4*DIGITS-1:0] data_in,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic                load_valid,
    output logic                load_ready,
    output logic [DIGITS-1:0]   an,
    output logic [6:0]          seg,
    output logic                dp
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    // Scan state
    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    // Display and pending registers
    logic [4*DIGITS-1:0] disp_data_q, disp_data_d;
    logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [4*DIGITS-1:0] pend_data_q;
    logic [DIGITS-1:0]   pend_dp_q;
    logic                pend_valid_q, pend_valid_d;
    // Registered outputs
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;

    logic                tick;
    logic                frame_end;
    logic                load_fire;
    logic [DIGITS-1:0]   blank_vec;
    logic                zero_above;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;

    // Hex nibble to active-high {g,f,e,d,c,b,a}.
    function automatic logic [6:0] font7(input logic [3:0] nib);
        case (nib)
            4'h0: font7 = 7'h3F;
            4'h1: font7 = 7'h06;
            4'h2: font7 = 7'h5B;
            4'h3: font7 = 7'h4F;
            4'h4: font7 = 7'h66;
            4'h5: font7 = 7'h6D;
            4'h6: font7 = 7'h7D;
            4'h7: font7 = 7'h07;
            4'h8: font7 = 7'h7F;
            4'h9: font7 = 7'h6F;
            4'hA: font7 = 7'h77;
            4'hB: font7 = 7'h7C;
            4'hC: font7 = 7'h39;
            4'hD: font7 = 7'h5E;
            4'hE: font7 = 7'h79;
            4'hF: font7 = 7'h71;
        endcase
    endfunction

    assign tick       = en && (presc_q == PRESC_LAST);
    assign frame_end  = tick && (idx_q == IDX_LAST);
    assign load_ready = ~pend_valid_q;
    assign load_fire  = en && load_valid && load_ready;

    // Next-state logic for the prescaler, digit index and display staging.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
        presc_d      = presc_q;
        idx_d        = idx_q;
        disp_data_d  = disp_data_q;
        disp_dp_d    = disp_dp_q;
        pend_valid_d = pend_valid_q;
        if (en) begin
            if (tick) begin
                presc_d = '0;
                idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
        // A load accepted on a boundary edge sees pending empty, so it waits a full frame.
        if (frame_end && pend_valid_q) begin
            disp_data_d  = pend_data_q;
            disp_dp_d    = pend_dp_q;
            pend_valid_d = 1'b0;
        end else if (load_fire) begin
            pend_valid_d = 1'b1;
        end
    end

    // Leading-zero mask: digit k>0 is blankable when it and every higher digit are zero.
    always_comb begin
        zero_above = 1'b1;
        blank_vec  = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            // NOTE: blocking '=' is intended here; zero_above must carry its updated value into the next iteration.
            zero_above = zero_above && (disp_data_q[4*k +: 4] == 4'h0);
            if (k != 0) begin
                blank_vec[k] = zero_above;
            end
        end
    end

    // Select the current digit's nibble, dp bit and blanking flag.
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_nib   = disp_data_q[4*k +: 4];
                cur_dp    = disp_dp_q[k];
                cur_blank = blank_vec[k];
            end
        end
    end

    // Output next values; blank_lz is applied live, a blanked digit keeps its anode and dp.
    always_comb begin
        an_d  = en ? (DIGITS'(1) << idx_q) : '0;
        seg_d = (en && !(blank_lz && cur_blank)) ? font7(cur_nib) : 7'h00;
        dp_d  = en && cur_dp;
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q      <= '0;
            idx_q        <= '0;
            disp_data_q  <= '0;
            disp_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            an_q         <= '0;
            seg_q        <= '0;
            dp_q         <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            disp_data_q  <= disp_data_d;
            disp_dp_q    <= disp_dp_d;
            pend_valid_q <= pend_valid_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    // Pending payload capture on an accepted load.
    always_ff @(posedge clk) begin
        // NOTE: no reset on this data path; it is only consumed while pend_valid_q is set, which is reset.
        if (!rst && load_fire) begin
            pend_data_q <= data_in;
            pend_dp_q   <= dp_in;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_multi_digit_display_driver.sv
// Self-checking bench for multi_digit_display_driver: a reference model pushes
// the expected outputs for every cycle into a queue and a monitor pops and
// compares them; directed scenarios add fixed-value checks on top.
module tb_multi_digit_display_driver;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        blank_lz;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        load_valid;
    logic        rdy0, rdy1;
    logic [3:0]  an0, an1;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1;

    int n_checks = 0;
    int n_errors = 0;

    int font_tab [16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                          'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};

    typedef struct packed {
        logic [31:0] presc;
        logic [31:0] idx;
        logic [31:0] disp;
        logic [31:0] ddp;
        logic        pend;
        logic [31:0] pval;
        logic [31:0] pdp;
    } mst_t;

    typedef struct packed {
        logic [31:0] an;
        logic [31:0] seg;
        logic [31:0] dp;
        logic [31:0] rdy;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    mst_t st0 = '0;
    mst_t st1 = '0;

    always #5 clk = ~clk;

    multi_digit_display_driver #(.DIGITS(4), .SCAN_DIV(4)) u_dut (
        .clk(clk), .rst(rst), .en(en), .blank_lz(blank_lz),
        .data_in(data_in), .dp_in(dp_in), .load_valid(load_valid),
        .load_ready(rdy0), .an(an0), .seg(seg0), .dp(dp0)
    );

    multi_digit_display_driver #(.DIGITS(4), .SCAN_DIV(1)) u_dut_fast (
        .clk(clk), .rst(rst), .en(en), .blank_lz(blank_lz),
        .data_in(data_in), .dp_in(dp_in), .load_valid(load_valid),
        .load_ready(rdy1), .an(an1), .seg(seg1), .dp(dp1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // What the display shows this cycle given the model state.
    function automatic exp_t model_out(input mst_t s, input logic en_v, input logic blz);
        exp_t e;
        logic [31:0] upper;
        e = '0;
        if (en_v) begin
            upper = s.disp >> (4 * s.idx);
            e.an  = 32'd1 << s.idx;
            e.seg = (blz && s.idx != 0 && upper == 0) ? 32'd0 : 32'(font_tab[upper[3:0]]);
            e.dp  = (s.ddp >> s.idx) & 32'd1;
        end
        return e;
    endfunction

    // One clock of the driver's behaviour, written from its functional rules.
    function automatic mst_t model_next(input mst_t s, input logic rst_v, input logic en_v,
                                        input logic lv, input logic [15:0] din,
                                        input logic [3:0] dpin, input int sd);
        mst_t n;
        logic tick;
        n = s;
        if (rst_v) begin
            n = '0;
        end else if (en_v) begin
            tick = (s.presc == 32'(sd - 1));
            if (s.pend) begin
                if (tick && s.idx == D - 1) begin
                    n.disp = s.pval;
                    n.ddp  = s.pdp;
                    n.pend = 1'b0;
                end
            end else if (lv) begin
                n.pend = 1'b1;
                n.pval = 32'(din);
                n.pdp  = 32'(dpin);
            end
            n.presc = tick ? 32'd0 : s.presc + 1;
            if (tick) n.idx = (s.idx + 1) % D;
        end
        return n;
    endfunction

    // Reference model: predict the outputs that follow this edge.
    always @(posedge clk) begin
        mst_t n0, n1;
        exp_t e0, e1;
        n0 = model_next(st0, rst, en, load_valid, data_in, dp_in, 4);
        n1 = model_next(st1, rst, en, load_valid, data_in, dp_in, 1);
        e0 = rst ? '0 : model_out(st0, en, blank_lz);
        e1 = rst ? '0 : model_out(st1, en, blank_lz);
        e0.rdy = {31'd0, ~n0.pend};
        e1.rdy = {31'd0, ~n1.pend};
        exp_q0.push_back(e0);
        exp_q1.push_back(e1);
        st0 <= n0;
        st1 <= n1;
    end

    // Monitor: compare the presented outputs against the queued expectations.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            check("sb_an",  32'(an0),  e.an);
            check("sb_seg", 32'(seg0), e.seg);
            check("sb_dp",  32'(dp0),  e.dp);
            check("sb_rdy", 32'(rdy0), e.rdy);
        end
        if (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            check("sb_fast_an",  32'(an1),  e.an);
            check("sb_fast_seg", 32'(seg1), e.seg);
            check("sb_fast_rdy", 32'(rdy1), e.rdy);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 40 && !rdy0; i++) step(1);
        check("wait_ready", 32'(rdy0), 32'd1);
    endtask

    task automatic load0(input logic [15:0] d, input logic [3:0] p);
        wait_ready();
        data_in    = d;
        dp_in      = p;
        load_valid = 1'b1;
        step(1);
        load_valid = 1'b0;
    endtask

    task automatic check_digit(input string name, input logic [3:0] pat,
                               input logic [6:0] s, input logic d);
        for (int i = 0; i < 40 && an0 != pat; i++) step(1);
        check({name, "_an"},  32'(an0),  32'(pat));
        check({name, "_seg"}, 32'(seg0), 32'(s));
        check({name, "_dp"},  32'(dp0),  32'(d));
    endtask

    initial begin
        int acc[$];
        rst = 1'b1; en = 1'b0; blank_lz = 1'b0;
        data_in = '0; dp_in = '0; load_valid = 1'b0;
        step(3);

        // Reset release: one dead cycle, then digit 0 showing "0".
        rst = 1'b0; en = 1'b1;
        check("rel_an0",  32'(an0),  32'd0);
        check("rel_seg0", 32'(seg0), 32'd0);
        check("rel_rdy",  32'(rdy0), 32'd1);
        check("rel_fast", 32'(an1),  32'd0);
        step(1);
        check("first_an",  32'(an0),  32'h1);
        check("first_seg", 32'(seg0), 32'h3F);
        check("fast_an_1", 32'(an1),  32'h1);
        step(1); check("fast_an_2", 32'(an1), 32'h2);
        step(1); check("fast_an_4", 32'(an1), 32'h4);
        step(1); check("fast_an_8", 32'(an1), 32'h8);
        step(1); check("fast_an_1b", 32'(an1), 32'h1);
        check("scan_an_2", 32'(an0), 32'h2);
        step(4); check("scan_an_4", 32'(an0), 32'h4); check("scan_seg_4", 32'(seg0), 32'h3F);
        step(4); check("scan_an_8", 32'(an0), 32'h8); check("scan_seg_8", 32'(seg0), 32'h3F);
        step(4); check("scan_an_1", 32'(an0), 32'h1);

        // Font.
        load0(16'h7A3F, 4'b0000);
        step(20);
        check_digit("font_d0", 4'h1, 7'h71, 1'b0);
        check_digit("font_d1", 4'h2, 7'h4F, 1'b0);
        check_digit("font_d2", 4'h4, 7'h77, 1'b0);
        check_digit("font_d3", 4'h8, 7'h07, 1'b0);

        // Anti-tearing: load mid-frame, old value holds through digit 3.
        check_digit("tear_pre", 4'h2, 7'h4F, 1'b0);
        load0(16'h1234, 4'b0000);
        check("tear_rdy_low", 32'(rdy0), 32'd0);
        for (int i = 0; i < 40 && !rdy0; i++) step(1);
        check("tear_rdy_back", 32'(rdy0), 32'd1);
        check("tear_last_an",  32'(an0),  32'h8);
        check("tear_last_seg", 32'(seg0), 32'h07);
        step(1);
        check("tear_new_an",  32'(an0),  32'h1);
        check("tear_new_seg", 32'(seg0), 32'h66);
        check_digit("tear_d1", 4'h2, 7'h4F, 1'b0);
        check_digit("tear_d2", 4'h4, 7'h5B, 1'b0);
        check_digit("tear_d3", 4'h8, 7'h06, 1'b0);

        // Leading-zero blanking.
        blank_lz = 1'b1;
        load0(16'h0050, 4'b0100);
        step(20);
        check_digit("lz_d3", 4'h8, 7'h00, 1'b0);
        check_digit("lz_d2", 4'h4, 7'h00, 1'b1);
        check_digit("lz_d1", 4'h2, 7'h6D, 1'b0);
        check_digit("lz_d0", 4'h1, 7'h3F, 1'b0);
        load0(16'h0000, 4'b0000);
        step(20);
        check_digit("lz0_d3", 4'h8, 7'h00, 1'b0);
        check_digit("lz0_d2", 4'h4, 7'h00, 1'b0);
        check_digit("lz0_d1", 4'h2, 7'h00, 1'b0);
        check_digit("lz0_d0", 4'h1, 7'h3F, 1'b0);
        blank_lz = 1'b0;

        // Back-pressure: continuous valid gives one accept per frame.
        wait_ready();
        load_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            data_in = 16'($urandom);
            dp_in   = 4'($urandom);
            if (rdy0) acc.push_back(c);
            step(1);
        end
        if (acc.size() >= 4) begin
            check("bp_gap1", 32'(acc[2] - acc[1]), 32'd16);
            check("bp_gap2", 32'(acc[3] - acc[2]), 32'd16);
        end else begin
            check("bp_accepts", 32'(acc.size()), 32'd4);
        end
        for (int i = 0; i < 40 && rdy0; i++) step(1);
        check("bp_pending", 32'(rdy0), 32'd0);
        load_valid = 1'b0;

        // Reset mid-frame with a load pending.
        step(3);
        rst = 1'b1;
        step(2);
        check("rst_an",  32'(an0),  32'd0);
        check("rst_seg", 32'(seg0), 32'd0);
        check("rst_dp",  32'(dp0),  32'd0);
        rst = 1'b0;
        check("rst_rdy", 32'(rdy0), 32'd1);
        step(20);
        check_digit("rst_d0", 4'h1, 7'h3F, 1'b0);
        check_digit("rst_d1", 4'h2, 7'h3F, 1'b0);
        check_digit("rst_d3", 4'h8, 7'h3F, 1'b0);

        // Enable low freezes scanning and blanks outputs.
        load0(16'h9C8E, 4'b1010);
        step(22);
        en = 1'b0;
        step(10);
        check("dis_an",  32'(an0),  32'd0);
        check("dis_seg", 32'(seg0), 32'd0);
        check("dis_dp",  32'(dp0),  32'd0);
        en = 1'b1;
        step(20);

        // Randomised traffic, checked by the scoreboard.
        for (int c = 0; c < 600; c++) begin
            rst        = ($urandom_range(0, 79) == 0);
            en         = ($urandom_range(0, 7) != 0);
            load_valid = ($urandom_range(0, 2) == 0);
            data_in    = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 4)));
            dp_in      = 4'($urandom);
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
            step(1);
        end
        rst = 1'b0; en = 1'b1; load_valid = 1'b0;
        step(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multi_digit_display_driver.md
MULTI_DIGIT_DISPLAY_DRIVER -- requirements
Module: multi_digit_display_driver

Interface
REQ-001 Parameter DIGITS, default 4, SHALL set the number of multiplexed digits; legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 1000, SHALL set the clock cycles per digit slot; legal range >=1.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 en  input  1  SHALL be the display enable; 0 blanks all outputs and freezes scanning.
REQ-006 blank_lz  input  1  SHALL enable leading-zero blanking.
REQ-007 data_in  input  4*DIGITS  SHALL carry hex nibbles; nibble k = data_in[4k+3:4k] = digit k, where digit 0 is least significant.
REQ-008 dp_in  input  DIGITS  SHALL carry per-digit decimal-point requests.
REQ-009 load_valid  input  1  SHALL be the load request from the producer.
REQ-010 load_ready  output  1  SHALL indicate that the driver can accept a load.
REQ-011 an  output  DIGITS  SHALL be the one-hot, active-high digit select.
REQ-012 seg  output  7  SHALL be the active-high segments {g,f,e,d,c,b,a}.
REQ-013 dp  output  1  SHALL be the active-high decimal point of the selected digit.

Function
REQ-014 Load handshake: data_in and dp_in SHALL be captured into a pending register on a cycle where load_valid=1 and load_ready=1; load_ready SHALL equal NOT pending_valid (combinational).
REQ-015 Pending contents SHALL be transferred to the display register only on a frame boundary (tick with idx=DIGITS-1); pending_valid SHALL clear on the same edge. The display never changes mid-frame (no tearing).
REQ-016 If a load is accepted on the same edge as a frame boundary with pending empty, that load SHALL be applied at the next frame boundary, not the current one.
REQ-017 Prescaler: counts 0..SCAN_DIV-1 while en=1; tick SHALL be asserted when prescaler=SCAN_DIV-1, and the prescaler SHALL wrap to 0; SCAN_DIV=1 SHALL produce a tick every cycle.
REQ-018 On each tick, digit index idx SHALL advance by 1, and wrap from DIGITS-1 to 0; DIGITS=1 keeps idx=0 with frame boundaries still occurring on every tick.
REQ-019 While en=0: prescaler, idx and the display register SHALL hold, the load handshake and pending transfer SHALL stay inactive, and an, seg and dp SHALL be registered to 0.
REQ-020 an, seg and dp SHALL be registered; they reflect idx and the display register of the previous cycle, giving one cycle of latency after an idx change.
REQ-021 an SHALL have only bit idx set when en=1; it SHALL never have more than one bit set.
REQ-022 The font for seg, given in hex for nibble values 0..F, SHALL be: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
REQ-023 Leading-zero blanking: with blank_lz=1, digit k>0 SHALL show seg=0 when digit k and all higher digits are 0; digit 0 SHALL never be blanked.
REQ-024 A blanked digit SHALL still assert its an bit. Its dp SHALL still follow the stored dp bit.
REQ-025 blank_lz SHALL be sampled live, not latched by a load, and SHALL take effect on the next output register update.

Reset
REQ-026 While rst=1: prescaler=0, idx=0, display data=0, display dp=0, pending_valid=0, an=0, seg=0, dp=0.
REQ-027 rst SHALL have priority over en and load_valid; a load presented during reset is not accepted.
REQ-028 load_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-029 Reset asserted mid-frame or with a load pending SHALL discard the pending data. After release, scanning SHALL restart at idx=0.
REQ-030 In the first cycle after reset with en=1, an, seg and dp SHALL still be 0; on the second cycle, an=0001 and seg=3F.

Verification
REQ-031 The bench SHALL use DIGITS=4 and SCAN_DIV=4 unless a scenario states otherwise.
REQ-032 Scan: en=1 after reset -> an SHALL step 0001,0010,0100,1000,0001 every 4 cycles with seg=3F throughout.
REQ-033 Font: load 0x7A3F, then wait one frame -> seg SHALL be 71, 4F, 77, 07 on an=0001,0010,0100,1000 respectively.
REQ-034 Anti-tearing: load 0x1234 at idx=1 mid-frame -> the old value SHALL hold until after the idx 3->0 tick; load_ready=0 until the transfer edge, then 1.
REQ-035 Blanking: blank_lz=1, load 0x0050, dp_in=0100 -> digit 3 seg=00; digit 2 seg=00 with dp=1; digit 1 seg=6D; digit 0 seg=3F. Load 0x0000 -> only digit 0 shows seg=3F.
REQ-036 Back-pressure and reset: hold load_valid=1 across two frames -> exactly one load per frame. Then assert rst mid-frame with a load pending -> an=0, seg=0, the pending data is lost, and the display shows 0 after release.
REQ-037 Enable and SCAN_DIV=1: en=0 for 10 cycles -> outputs are 0 and idx is frozen; on re-enable, scanning resumes at the frozen idx. With SCAN_DIV=1, an rotates every cycle.
